// File: rtl/xs3_counter_pkg.sv
// Excess-3 digit codes, digit type and legal-code check shared by the
// counter and the converter side.
package xs3_pkg;

   typedef logic [3:0] xs3_t;

   localparam xs3_t XS3_ZERO = 4'b0011;
   localparam xs3_t XS3_NINE = 4'b1100;
   localparam xs3_t XS3_STEP = 4'b0001;

   function automatic logic xs3_valid(input xs3_t d);
      return (d >= XS3_ZERO) && (d <= XS3_NINE);
   endfunction

endpackage

// File: rtl/xs3_counter_if.sv
// Control/data bundle of the XS-3 decade counter; master drives controls,
// slave (the counter) drives q, tc and load_err.
interface xs3_counter_if #(
   parameter int unsigned NDIG = 2
);

   logic                clr;
   logic                load;
   logic [4*NDIG-1:0]   load_val;
   logic                en;
   logic                dir;
   logic [4*NDIG-1:0]   q;
   logic                tc;
   logic                load_err;

   modport master (
      output clr, load, load_val, en, dir,
      input  q, tc, load_err
   );

   modport slave (
      input  clr, load, load_val, en, dir,
      output q, tc, load_err
   );

endinterface

// File: rtl/xs3_counter_digit.sv
// One XS-3 decade cell: steps the digit by one in the selected direction
// and flags a carry (up) or borrow (down) when it wraps.
module xs3_digit
   import xs3_pkg::*;
(
   input  xs3_t i_digit,
   input  logic en_in,
   input  logic dir,
   output xs3_t o_digit_next,
   output logic carry_out
);

   always_comb begin
      o_digit_next = i_digit;
      carry_out    = 1'b0;
      if (en_in) begin
         if (dir) begin
            if (i_digit == XS3_ZERO) begin
               o_digit_next = XS3_NINE;
               carry_out    = 1'b1;
            end else begin
               o_digit_next = i_digit - XS3_STEP;
            end
         end else begin
            if (i_digit == XS3_NINE) begin
               o_digit_next = XS3_ZERO;
               carry_out    = 1'b1;
            end else begin
               o_digit_next = i_digit + XS3_STEP;
            end
         end
      end
   end

endmodule

// File: rtl/xs3_counter.sv
// Multi-digit XS-3 decade counter with validated parallel load and terminal
// count. Down counting is built only when XS3_CNT_DOWN_EN is defined.
module xs3_counter
   import xs3_pkg::*;
#(
   parameter int unsigned NDIG = 2
)
(
   input  logic              clk,
   input  logic              rst,
   xs3_counter_if.slave      bus
);

   localparam logic [4*NDIG-1:0] ALL_ZERO = {NDIG{XS3_ZERO}};

   logic [4*NDIG-1:0] r_q;
   logic              r_load_err;
   logic [4*NDIG-1:0] w_next;
   logic [NDIG-1:0]   w_en;
   logic [NDIG-1:0]   w_carry;
   logic              w_step;
   logic              w_dir;
   logic              w_load_ok;

`ifdef XS3_CNT_DOWN_EN
   assign w_dir = bus.dir;
`else
   logic w_unused_dir;
   assign w_unused_dir = bus.dir;
   assign w_dir        = 1'b0;
`endif

   assign w_step = bus.en & ~bus.load & ~bus.clr;

   always_comb begin
      w_load_ok = 1'b1;
      for (int unsigned i = 0; i < NDIG; i++) begin
         if (!xs3_valid(bus.load_val[4*i +: 4])) begin
            w_load_ok = 1'b0;
         end
      end
   end

   for (genvar g = 0; g < NDIG; g++) begin : g_digit
      if (g == 0) begin : g_first
         assign w_en[g] = w_step;
      end else begin : g_rest
         assign w_en[g] = w_carry[g-1];
      end

      xs3_digit u_digit (
         .i_digit      (r_q[4*g +: 4]),
         .en_in        (w_en[g]),
         .dir          (w_dir),
         .o_digit_next (w_next[4*g +: 4]),
         .carry_out    (w_carry[g])
      );
   end

   // w_next equals r_q whenever w_step is low, so the hold case needs no branch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q        <= ALL_ZERO;
         r_load_err <= 1'b0;
      end else begin
         r_load_err <= 1'b0;
         if (bus.clr) begin
            r_q <= ALL_ZERO;
         end else if (bus.load) begin
            if (w_load_ok) begin
               r_q <= bus.load_val;
            end else begin
               r_load_err <= 1'b1;
            end
         end else begin
            r_q <= w_next;
         end
      end
   end

   // The top digit only carries when every digit is at its wrap code while
   // stepping, which is exactly the terminal-count condition.
   assign bus.tc       = w_carry[NDIG-1];
   assign bus.q        = r_q;
   assign bus.load_err = r_load_err;

endmodule
